// File: rtl/hkspi_pkg.sv
// Shared constants and state encoding for the housekeeping SPI stream sequencer.
// States are plain localparams so older tools that lack enum support can still read them.
package hkspi_pkg;

  localparam logic [7:0] HKSPI_CMD_WRITE      = 8'h80;
  localparam logic [7:0] HKSPI_CMD_READ       = 8'h40;
  localparam logic [7:0] HKSPI_REG_PRODUCT_ID = 8'h03;
  localparam logic [7:0] HKSPI_REG_EXT_RESET  = 8'h0b;

  typedef logic [2:0] hkspi_state_t;

  localparam hkspi_state_t ST_IDLE       = 3'd0;
  localparam hkspi_state_t ST_CS_SETUP   = 3'd1;
  localparam hkspi_state_t ST_SHIFT      = 3'd2;
  localparam hkspi_state_t ST_WAIT_WDATA = 3'd3;
  localparam hkspi_state_t ST_CS_HOLD    = 3'd4;
  localparam hkspi_state_t ST_CS_IDLE    = 3'd5;

  function automatic logic [7:0] hkspi_cmd_byte(input logic write);
    return write ? HKSPI_CMD_WRITE : HKSPI_CMD_READ;
  endfunction

endpackage

// File: rtl/hkspi_shift.sv
// Mode-0 byte shifter: one byte per load, MSB first, sck low then high for CLK_DIV cycles each.
// byte_done is high during the last high cycle so the next byte can be loaded without a gap.
module hkspi_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out,
  output logic       byte_done,
  output logic       sck,
  output logic       sdi,
  input  logic       sdo
);

  logic       active;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       phase_end;

  assign phase_end = active && (div_cnt == 8'(CLK_DIV - 1));
  assign byte_done = phase_end && sck && (bit_cnt == 3'd0);
  assign byte_out  = shreg;

  // The shift register doubles as receiver: sdo enters at the bottom on each rising sck.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      sck     <= 1'b0;
      sdi     <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd7;
      shreg   <= byte_in;
      sck     <= 1'b0;
      sdi     <= byte_in[7];
    end else if (phase_end) begin
      div_cnt <= 8'd0;
      if (!sck) begin
        sck   <= 1'b1;
        shreg <= {shreg[6:0], sdo};
      end else begin
        sck <= 1'b0;
        if (bit_cnt == 3'd0) begin
          active <= 1'b0;
          sdi    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 3'd1;
          sdi     <= shreg[7];
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/hkspi_seq.sv
// Housekeeping SPI stream master: command, address, then cmd_len+1 data bytes per transaction.
// The transaction FSM and byte counter live here; bit timing lives in hkspi_shift.
module hkspi_seq import hkspi_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [7:0]       wdata,
  output logic             rdata_valid,
  output logic [7:0]       rdata,
  output logic             done,
  output logic             busy,
  output logic             spi_sck,
  output logic             spi_csb,
  output logic             spi_sdi,
  input  logic             spi_sdo
);

  localparam int IW = LEN_W + 1;

  hkspi_state_t   state;
  logic           is_write;
  logic [7:0]     addr_q;
  logic [LEN_W-1:0] len_q;
  logic [IW-1:0]  byte_idx;
  logic [8:0]     phase_cnt;
  logic           last_byte;
  logic           wait_end;
  logic           idle_end;
  logic           shift_load;
  logic [7:0]     shift_byte;
  logic [7:0]     byte_out;
  logic           byte_done;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign last_byte = (byte_idx == IW'(len_q) + IW'(2));
  assign wait_end  = (phase_cnt == 9'(CLK_DIV - 1));
  assign idle_end  = (phase_cnt == 9'(2 * CLK_DIV - 1));

  hkspi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .load      (shift_load),
    .byte_in   (shift_byte),
    .byte_out  (byte_out),
    .byte_done (byte_done),
    .sck       (spi_sck),
    .sdi       (spi_sdi),
    .sdo       (spi_sdo)
  );

  // Next byte is chosen at the byte boundary; write data that is not ready sends us to WAIT_WDATA.
  always_comb begin
    shift_load  = 1'b0;
    shift_byte  = 8'h00;
    wdata_ready = 1'b0;
    case (state)
      ST_CS_SETUP: begin
        if (wait_end) begin
          shift_load = 1'b1;
          shift_byte = hkspi_cmd_byte(is_write);
        end
      end
      ST_SHIFT: begin
        if (byte_done && !last_byte) begin
          if (byte_idx == IW'(0)) begin
            shift_load = 1'b1;
            shift_byte = addr_q;
          end else if (!is_write) begin
            shift_load = 1'b1;
          end else begin
            wdata_ready = 1'b1;
            shift_load  = wdata_valid;
            shift_byte  = wdata;
          end
        end
      end
      ST_WAIT_WDATA: begin
        wdata_ready = 1'b1;
        shift_load  = wdata_valid;
        shift_byte  = wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      addr_q      <= 8'h00;
      len_q       <= '0;
      byte_idx    <= '0;
      phase_cnt   <= 9'd0;
      spi_csb     <= 1'b1;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            is_write  <= cmd_write;
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            spi_csb   <= 1'b0;
            phase_cnt <= 9'd0;
            state     <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (wait_end) begin
            byte_idx <= '0;
            state    <= ST_SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 9'd1;
          end
        end
        ST_SHIFT: begin
          if (byte_done) begin
            if (!is_write && (byte_idx > IW'(1))) begin
              rdata       <= byte_out;
              rdata_valid <= 1'b1;
            end
            if (last_byte) begin
              phase_cnt <= 9'd0;
              state     <= ST_CS_HOLD;
            end else begin
              byte_idx <= byte_idx + IW'(1);
              if (!shift_load) state <= ST_WAIT_WDATA;
            end
          end
        end
        ST_WAIT_WDATA: begin
          if (wdata_valid) state <= ST_SHIFT;
        end
        ST_CS_HOLD: begin
          if (wait_end) begin
            spi_csb   <= 1'b1;
            done      <= 1'b1;
            phase_cnt <= 9'd0;
            state     <= ST_CS_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 9'd1;
          end
        end
        ST_CS_IDLE: begin
          if (idle_end) state <= ST_IDLE;
          else          phase_cnt <= phase_cnt + 9'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hkspi_seq.sv
// Randomised scoreboard bench for hkspi_seq against a housekeeping SPI slave model.
// Expected bytes come from a register-array reference model updated when each command is issued.
module tb_hkspi_seq;

  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 4;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [7:0]       cmd_addr = 8'h00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wdata_valid = 1'b0;
  logic             wdata_ready;
  logic [7:0]       wdata = 8'h00;
  logic             rdata_valid;
  logic [7:0]       rdata;
  logic             done;
  logic             busy;
  logic             spi_sck;
  logic             spi_csb;
  logic             spi_sdi;
  logic             spi_sdo = 1'b0;

  hkspi_seq #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .done        (done),
    .busy        (busy),
    .spi_sck     (spi_sck),
    .spi_csb     (spi_csb),
    .spi_sdi     (spi_sdi),
    .spi_sdo     (spi_sdo)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_edge = -1;

  logic [7:0] exp_sdi[$];
  logic [7:0] exp_rdata[$];
  int         exp_lat[$];
  logic [7:0] wq[$];
  logic [7:0] ref_regs [256];
  logic [7:0] s_regs [256];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic noteFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event did not happen as required", name);
  endtask

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Slave model: shifts in on rising sck, presents read data MSB on the falling edge before it is sampled.
  logic [7:0] s_sr, s_tx, s_cmd, s_addr;
  int s_bits, s_nbytes;
  always @(posedge spi_sck or negedge spi_sck or posedge spi_csb or negedge spi_csb) begin
    if (spi_csb === 1'b1) begin
      s_bits = 0;
      s_nbytes = 0;
      s_tx = 8'h00;
    end else if (spi_sck === 1'b1) begin
      s_sr = {s_sr[6:0], spi_sdi};
      s_bits++;
      if (s_bits == 8) begin
        s_bits = 0;
        if (exp_sdi.size() == 0) noteFail("sdi_extra_byte");
        else checkOutput("sdi_byte", s_sr, exp_sdi.pop_front());
        if (s_nbytes == 0) s_cmd = s_sr;
        else if (s_nbytes == 1) s_addr = s_sr;
        else if (s_cmd == 8'h80) begin
          s_regs[s_addr] = s_sr;
          s_addr++;
        end
        s_nbytes++;
        if (s_cmd == 8'h40 && s_nbytes >= 2) begin
          s_tx = s_regs[s_addr];
          s_addr++;
        end
      end
    end else begin
      spi_sdo = s_tx[7];
      s_tx = {s_tx[6:0], 1'b0};
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data or completion.
  logic prev_csb = 1'b1;
  logic prev_stall = 1'b0;
  bit   seen_low = 0;
  int   csb_hi = 0;
  int   lat;
  always begin
    @(negedge wb_clk_i);
    #1;
    if (wb_rst_i) begin
      prev_csb = 1'b1;
      prev_stall = 1'b0;
      seen_low = 0;
      csb_hi = 0;
    end else begin
      if (cmd_valid && cmd_ready) accept_edge = cyc + 1;
      if (rdata_valid) begin
        if (exp_rdata.size() == 0) noteFail("rdata_unexpected");
        else checkOutput("rdata", rdata, exp_rdata.pop_front());
      end
      if (done) begin
        if (exp_lat.size() == 0) noteFail("done_unexpected");
        else begin
          lat = exp_lat.pop_front();
          if (lat >= 0) checkOutput("done_latency", cyc - accept_edge, lat);
        end
        checkOutput("csb_at_done", spi_csb, 1'b1);
      end
      if (!spi_csb) begin
        checkOutput("cmd_ready_low", cmd_ready, 1'b0);
        checkOutput("busy_high", busy, 1'b1);
      end
      if (prev_csb && !spi_csb && seen_low) begin
        total++;
        if (csb_hi < 2 * CLK_DIV) begin
          bad++;
          $display("[TB] FAIL csb_gap: got %0d cycles need >= %0d", csb_hi, 2 * CLK_DIV);
        end
      end
      if (!prev_csb && spi_csb) checkOutput("done_with_csb_rise", done, 1'b1);
      if (prev_stall && wdata_ready && !wdata_valid) begin
        checkOutput("stall_sck", spi_sck, 1'b0);
        checkOutput("stall_csb", spi_csb, 1'b0);
      end
      prev_stall = wdata_ready && !wdata_valid;
      csb_hi = spi_csb ? csb_hi + 1 : 0;
      if (!spi_csb) seen_low = 1;
      prev_csb = spi_csb;
    end
  end

  task automatic expectTxn(input bit wr, input logic [7:0] addr, input int len, input bit timed);
    logic [7:0] a;
    exp_sdi.push_back(wr ? 8'h80 : 8'h40);
    exp_sdi.push_back(addr);
    for (int i = 0; i <= len; i++) begin
      a = addr + 8'(i);
      if (wr) begin
        exp_sdi.push_back(wq[i]);
        ref_regs[a] = wq[i];
      end else begin
        exp_sdi.push_back(8'h00);
        exp_rdata.push_back(ref_regs[a]);
      end
    end
    exp_lat.push_back(timed ? (2 + (len + 3) * 16) * CLK_DIV : -1);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!done) noteFail("done_timeout");
  endtask

  task automatic driveTxn(input bit wr, input logic [7:0] addr, input int len,
                          input int stall_at, input int stall_cyc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = LEN_W'(len);
    while (!cmd_ready && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!cmd_ready) begin
      noteFail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_len   = LEN_W'($urandom);
    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        if (i == stall_at) repeat (stall_cyc) @(negedge wb_clk_i);
        wdata = wq[i];
        wdata_valid = 1'b1;
        n = 0;
        while (!wdata_ready && n < 2000) begin
          @(negedge wb_clk_i);
          n++;
        end
        if (!wdata_ready) noteFail("wdata_timeout");
        @(negedge wb_clk_i);
        wdata_valid = 1'b0;
        wdata = 8'($urandom);
      end
    end
    waitDone();
  endtask

  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input int len,
                               input int stall_at, input int stall_cyc);
    logic [7:0] a;
    expectTxn(wr, addr, len, stall_cyc == 0);
    driveTxn(wr, addr, len, stall_at, stall_cyc);
    @(negedge wb_clk_i);
    checkOutput("sdi_left", exp_sdi.size(), 0);
    checkOutput("rdata_left", exp_rdata.size(), 0);
    if (wr) begin
      for (int i = 0; i <= len; i++) begin
        a = addr + 8'(i);
        checkOutput("slave_reg", s_regs[a], ref_regs[a]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit wr;
    logic [7:0] addr;
    int len, stall, sat;

    for (int i = 0; i < 256; i++) begin
      ref_regs[i] = 8'h00;
      s_regs[i]   = 8'h00;
    end
    ref_regs[1] = 8'h04; ref_regs[2] = 8'h56; ref_regs[3] = 8'h11;
    s_regs[1]   = 8'h04; s_regs[2]   = 8'h56; s_regs[3]   = 8'h11;

    // Command held during reset must only be accepted once reset is gone.
    wq.delete();
    expectTxn(1'b0, 8'h03, 0, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03; cmd_len = '0;
    repeat (4) @(negedge wb_clk_i);
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_csb", spi_csb, 1'b1);
    checkOutput("rst_sck", spi_sck, 1'b0);
    checkOutput("rst_sdi", spi_sdi, 1'b0);
    checkOutput("rst_wdata_ready", wdata_ready, 1'b0);
    checkOutput("rst_rdata_valid", rdata_valid, 1'b0);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_done", done, 1'b0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    checkOutput("accept_after_reset_busy", busy, 1'b1);
    checkOutput("accept_after_reset_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    waitDone();
    @(negedge wb_clk_i);
    checkOutput("sdi_left", exp_sdi.size(), 0);
    checkOutput("rdata_left", exp_rdata.size(), 0);

    applyStimulus(1'b0, 8'h03, 0, 0, 0);

    wq.delete(); wq.push_back(8'h01);
    applyStimulus(1'b1, 8'h0b, 0, 0, 0);
    checkOutput("reg0b_first", s_regs[8'h0b], 8'h01);
    wq.delete(); wq.push_back(8'h00);
    applyStimulus(1'b1, 8'h0b, 0, 0, 0);
    checkOutput("reg0b_second", s_regs[8'h0b], 8'h00);

    applyStimulus(1'b0, 8'h00, 15, 0, 0);

    wq.delete(); wq.push_back(8'ha5); wq.push_back(8'h3c);
    applyStimulus(1'b1, 8'h20, 1, 1, 50);
    checkOutput("underflow_b0", s_regs[8'h20], 8'ha5);
    checkOutput("underflow_b1", s_regs[8'h21], 8'h3c);

    // Reset while bit 4 of the address byte is on the wire.
    wq.delete();
    expectTxn(1'b0, 8'h03, 0, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03; cmd_len = '0;
    begin
      int n = 0;
      while (!cmd_ready && n < 2000) begin
        @(negedge wb_clk_i);
        n++;
      end
      if (!cmd_ready) noteFail("cmd_accept_timeout");
    end
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    repeat (46) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("midrst_csb", spi_csb, 1'b1);
    checkOutput("midrst_sck", spi_sck, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    exp_sdi.delete();
    exp_rdata.delete();
    exp_lat.delete();
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    applyStimulus(1'b0, 8'h03, 0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 8'($urandom_range(0, 255));
      len   = $urandom_range(0, 6);
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      sat   = $urandom_range(0, len);
      wq.delete();
      for (int i = 0; i <= len; i++) wq.push_back(8'($urandom));
      applyStimulus(wr, addr, len, sat, wr ? stall : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
